// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory read port between fetch and debug, with a starvation guard
module imem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH_LOG2   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    input  logic        fetch_flush,
    output logic        fetch_resp_valid,
    output logic [31:0] fetch_resp_data,
    output logic        fetch_resp_err,
    input  logic        dbg_valid,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ready,
    output logic        dbg_resp_valid,
    output logic [31:0] dbg_resp_data,
    output logic        dbg_resp_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata
);
    localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [31:0] HI_MASK = ~((32'd1 << (DEPTH_LOG2 + 2)) - 32'd1);

    logic [3:0]  starve_cnt;
    logic        grant_dbg;
    logic        sel_err;
    logic [31:0] sel_data;

    // Fetch wins unless debug has waited STARVE_LIMIT cycles; the address error check runs on whichever address was granted
    always_comb begin
        grant_dbg   = dbg_valid && (!fetch_valid || starve_cnt == LIMIT);
        dbg_ready   = grant_dbg;
        fetch_ready = fetch_valid && !grant_dbg;
        mem_addr    = grant_dbg ? dbg_addr : fetch_addr;
        sel_err     = (mem_addr[1:0] != 2'b00) || ((mem_addr & HI_MASK) != 32'd0);
        sel_data    = sel_err ? 32'd0 : mem_rdata;
    end

    // Counts consecutive cycles debug loses to fetch, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= 4'd0;
        else if (grant_dbg || !dbg_valid)
            starve_cnt <= 4'd0;
        else if (fetch_ready && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // Fetch response: pulse unless flushed; payload captured on every acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_resp_valid <= 1'b0;
            fetch_resp_data  <= 32'd0;
            fetch_resp_err   <= 1'b0;
        end else begin
            fetch_resp_valid <= fetch_ready && !fetch_flush;
            if (fetch_ready) begin
                fetch_resp_data <= sel_data;
                fetch_resp_err  <= sel_err;
            end
        end
    end

    // Debug response: pulse after each grant; payload held between grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_resp_valid <= 1'b0;
            dbg_resp_data  <= 32'd0;
            dbg_resp_err   <= 1'b0;
        end else begin
            dbg_resp_valid <= grant_dbg;
            if (grant_dbg) begin
                dbg_resp_data <= sel_data;
                dbg_resp_err  <= sel_err;
            end
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for the instruction memory arbiter
module tb_imem_arbiter;
    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        e;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_addr = 32'd0;
    logic        fetch_ready;
    logic        fetch_flush = 1'b0;
    logic        fetch_resp_valid;
    logic [31:0] fetch_resp_data;
    logic        fetch_resp_err;
    logic        dbg_valid = 1'b0;
    logic [31:0] dbg_addr = 32'd0;
    logic        dbg_ready;
    logic        dbg_resp_valid;
    logic [31:0] dbg_resp_data;
    logic        dbg_resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    int    checks = 0;
    int    failures = 0;
    resp_t fq[$];
    resp_t dq[$];

    imem_arbiter #(.STARVE_LIMIT(4), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_flush(fetch_flush), .fetch_resp_valid(fetch_resp_valid),
        .fetch_resp_data(fetch_resp_data), .fetch_resp_err(fetch_resp_err),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
        .dbg_resp_valid(dbg_resp_valid), .dbg_resp_data(dbg_resp_data),
        .dbg_resp_err(dbg_resp_err), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h400);
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request cycle: drive at negedge, check grant and address, queue the response due next cycle
    task automatic step(input logic fv, input logic [31:0] fa, input logic fl,
                        input logic dv, input logic [31:0] da,
                        input logic efr, input logic edr);
        @(negedge clk);
        fetch_valid = fv;
        fetch_addr  = fa;
        fetch_flush = fl;
        dbg_valid   = dv;
        dbg_addr    = da;
        #1;
        check("fetch_ready", fetch_ready, efr);
        check("dbg_ready", dbg_ready, edr);
        check("mem_addr", mem_addr, edr ? da : fa);
        fq.push_back('{v: efr && !fl, d: addr_bad(fa) ? 32'd0 : mem_word(fa), e: addr_bad(fa)});
        dq.push_back('{v: edr, d: addr_bad(da) ? 32'd0 : mem_word(da), e: addr_bad(da)});
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_cleared();
        check("rst_fetch_valid", fetch_resp_valid, 32'd0);
        check("rst_fetch_data", fetch_resp_data, 32'd0);
        check("rst_fetch_err", fetch_resp_err, 32'd0);
        check("rst_dbg_valid", dbg_resp_valid, 32'd0);
        check("rst_dbg_data", dbg_resp_data, 32'd0);
        check("rst_dbg_err", dbg_resp_err, 32'd0);
    endtask

    // Response monitor: pops the entry queued in the previous cycle
    always @(posedge clk) begin
        resp_t r;
        #2;
        if (fq.size() > 0) begin
            r = fq.pop_front();
            check("fetch_resp_valid", fetch_resp_valid, r.v);
            if (r.v) begin
                check("fetch_resp_data", fetch_resp_data, r.d);
                check("fetch_resp_err", fetch_resp_err, r.e);
            end
        end
        if (dq.size() > 0) begin
            r = dq.pop_front();
            check("dbg_resp_valid", dbg_resp_valid, r.v);
            if (r.v) begin
                check("dbg_resp_data", dbg_resp_data, r.d);
                check("dbg_resp_err", dbg_resp_err, r.e);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_cleared();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h40 + 32'(i * 4), 1'b0, 1'b1, 32'h80 + 32'(i * 8), i % 5 != 4, i % 5 == 4);
        idle();
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1);
        idle();
        step(1'b1, 32'h06, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h3FC, 1'b0, 1'b1);
        idle();
        step(1'b1, 32'h1C, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 32'h28, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h100 + 32'(i * 4), i == 4, 1'b1, 32'h200, i != 4, i == 4);
        idle();
        step(1'b1, 32'h30, 1'b0, 1'b1, 32'h34, 1'b1, 1'b0);
        step(1'b1, 32'h38, 1'b0, 1'b1, 32'h34, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        fq.delete();
        dq.delete();
        #1;
        check_cleared();
        fetch_valid = 1'b0;
        dbg_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_cleared();
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h60 + 32'(i * 4), 1'b0, 1'b1, 32'h70, i != 4, i == 4);
        idle();
        idle();
        @(posedge clk);
        #3;
        check("queue_drained", 32'(fq.size() + dq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single combinational read port of the instruction memory between the pipeline fetch stage and a debug/loader requester. Requests are presented at the memory address in the same cycle. Read data is registered and returned one cycle later. Fetch has priority, but a starvation counter guarantees debug forward progress. The block sits between the IF stage, the debug port, and the instruction memory.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive debug-denied cycles before debug is forced a grant; legal range 1..15.
- `DEPTH_LOG2`, default 8: log2 of memory depth in words (256 words = byte addresses 0x000-0x3FF).

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `fetch_valid`  in  1  fetch request present
- `fetch_addr`  in  32  fetch byte address
- `fetch_ready`  out  1  fetch request accepted this cycle
- `fetch_flush`  in  1  cancel fetch response due next cycle
- `fetch_resp_valid`  out  1  fetch response pulse
- `fetch_resp_data`  out  32  fetch instruction word
- `fetch_resp_err`  out  1  fetch address misaligned or out of range
- `dbg_valid`  in  1  debug request present
- `dbg_addr`  in  32  debug byte address
- `dbg_ready`  out  1  debug request accepted this cycle
- `dbg_resp_valid`  out  1  debug response pulse
- `dbg_resp_data`  out  32  debug read word
- `dbg_resp_err`  out  1  debug address error
- `mem_addr`  out  32  address to instruction memory
- `mem_rdata`  in  32  combinational memory read data

## Operation
- Grant is combinational: `grant_dbg = dbg_valid && (!fetch_valid || starve_cnt == STARVE_LIMIT)`.
- `dbg_ready = grant_dbg`; `fetch_ready = fetch_valid && !grant_dbg`. At most one ready is high per cycle.
- `mem_addr` follows the granted port. It equals `fetch_addr` when no debug grant (including idle).
- `starve_cnt` has width 4.
  - Increments when `dbg_valid && fetch_ready`.
  - Clears when `grant_dbg` is high or `dbg_valid` is low.
  - Saturates at `STARVE_LIMIT`.
- Error check, on the accepted address:
  - Error when `addr[1:0] != 0` or any of `addr[31:DEPTH_LOG2+2]` is nonzero.
  - On error: `resp_err = 1` and `resp_data = 0`. Memory data is ignored.
- Responses have no backpressure. Requesters must consume a response in the cycle it is valid.
- Flush: if `fetch_flush` is high in the cycle a fetch is accepted, the response in the next cycle is suppressed.
  - `fetch_resp_valid` stays 0 for that response.
  - `fetch_ready` itself is not affected by flush.
- Response data/err registers update only on acceptance and hold otherwise. The valid signals are single-cycle pulses.

## Timing
- Latency: request accepted in cycle N → response valid in N+1, carrying `mem_rdata` sampled at the N/N+1 edge.
- Throughput: one accepted request per cycle total, back-to-back, on either port.
- Fairness:
  - With `fetch_valid` and `dbg_valid` held high, debug is granted exactly every `STARVE_LIMIT+1` cycles.
  - Fetch sees one bubble per debug grant.
- Simultaneous events:
  - Flush and a debug grant in the same cycle: no fetch accepted, so flush has no effect. The debug response is unaffected.
  - A response pulse and a new acceptance in the same cycle are legal (pipelined).
- Reset (async assert, synchronous deassert handled upstream):
  - All `*_resp_valid` = 0, `*_resp_data` = 0, `*_resp_err` = 0, `starve_cnt` = 0.
  - Reset asserted mid-operation drops any in-flight response. No pulse follows deassertion.

## Test plan
- Fetch only, addresses 0x00, 0x04, 0x08 in consecutive cycles → `fetch_resp_valid` high in each of the following 3 cycles with `mem_rdata` for each address, `err = 0`.
- Contention: both valid continuously, `STARVE_LIMIT = 4`:
  - `fetch_ready` pattern is 1,1,1,1,0 repeating; `dbg_ready` pattern is 0,0,0,0,1.
  - Debug response appears the cycle after each debug grant.
- Debug with fetch idle: `dbg_addr = 0x10` → `dbg_ready = 1` the same cycle, `dbg_resp_valid` next cycle, `mem_addr` = 0x10 during the grant.
- Errors:
  - `fetch_addr = 0x06` → `fetch_resp_err = 1`, `data = 0`.
  - `dbg_addr = 0x400` → `dbg_resp_err = 1`, `data = 0`.
- Flush: fetch accepted at 0x1C with `fetch_flush = 1` → no `fetch_resp_valid` next cycle; fetch at 0x28 the following cycle returns normally.
- Reset: assert `rst_n = 0` in the cycle after a fetch is accepted → `fetch_resp_valid` drops to 0 immediately; after release, all outputs are 0 and `starve_cnt` restarts from 0.
